iir_cfg_ctrl: RTL and testbench
===============================

// Module: iir_cfg_ctrl
// PURPOSE
//  Controller between the sample source and the IIR_1lookahead datapath. Holds a shadow
//  bank of the six coefficients (c0..c2, b0..b2), forwards samples to the filter and
//  applies coefficient updates atomically. On commit it stalls input, drains in-flight
//  samples (vin issued minus vout seen), then swaps shadow->active. Filter never sees mixed sets.
// PARAMETERS
//  W        9   sample/coefficient width
//  OUTW     4   width of outstanding-sample counter (max 2^OUTW-1 in flight)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst_n       in   1   asynchronous active-low reset
//  cfg_we      in   1   shadow write strobe
//  cfg_addr    in   3   0..5 = c0,c1,c2,b0,b1,b2; 6,7 invalid
//  cfg_data    in   W   shadow write data
//  cfg_commit  in   1   request swap shadow->active (pulse)
//  cfg_busy    out  1   1 while commit pending/draining/swapping
//  cfg_err     out  1   sticky: invalid addr write or vout with zero outstanding
//  din_up      in   W   upstream sample
//  vin_up      in   1   upstream valid
//  rdy_up      out  1   upstream ready; transfer when vin_up&rdy_up
//  din         out  W   sample to filter
//  vin         out  1   valid to filter
//  vout        in   1   filter output valid (drain tracking)
//  c0,c1,c2,b0,b1,b2 out W each  active coefficients to filter
// BEHAVIOUR
//  Reset: active+shadow coefs 0, din 0, vin 0, outstanding 0, cfg_err 0, state UNCFG.
//  States: UNCFG -(commit)-> DRAIN; RUN -(commit)-> DRAIN; DRAIN -(outstanding==0 and
//   no vin this cycle)-> SWAP; SWAP -> RUN (1 cycle).
//  rdy_up = (state==RUN) & ~cfg_commit; comb. UNCFG: rdy_up=0, input blocked until 1st commit.
//  Forwarding: registered, latency 1: vin<=vin_up&rdy_up; din<=din_up on transfer, else held.
//  Outstanding: +1 on vin, -1 on vout, unchanged if both. vout at 0: stays 0, cfg_err<=1.
//   Increment at max: saturate, cfg_err<=1.
//  Shadow write: cfg_we & addr<6 -> shadow[addr]<=cfg_data any state, any cycle;
//   addr>=6 -> ignored, cfg_err<=1.
//  SWAP cycle: active<=shadow value at start of that cycle; a cfg_we in the SWAP cycle
//   lands in shadow only, applied at the next commit.
//  cfg_we and cfg_commit same cycle: write included in that commit.
//  cfg_commit outside UNCFG/RUN: ignored (no queued second commit).
//  cfg_busy = state in {DRAIN,SWAP}; first cycle of DRAIN is cycle after commit.
//  Coefficient outputs change only on the SWAP->RUN edge; stable all other cycles.
//  Async reset mid-DRAIN/SWAP: returns to UNCFG, shadow contents lost.
// STRUCTURE
//  Package iir_cfg_pkg: state enum {UNCFG,RUN,DRAIN,SWAP}, addr constants
//   ADDR_C0..ADDR_B2, NCOEF=6.
//  Sub-module coef_bank: 6xW shadow+active regs, write port, swap strobe, flat outputs.
//  Top: FSM, forwarding register, outstanding counter, error flag.
// TESTING
//  1 Reset, vin_up=1 -> rdy_up=0, vin=0, all coefs 0 until first commit.
//  2 Write c0..b2=1..6, commit, vout pulses none -> busy 2 cycles, coefs=1..6, rdy_up=1.
//  3 RUN, 3 samples in flight, commit, new b0=0x1FF -> b0 unchanged until 3 vout seen,
//    then swaps next cycle; rdy_up=0 throughout drain.
//  4 cfg_we addr=5 and commit same cycle -> b2 new value after swap; write in SWAP cycle
//    -> not applied until next commit.
//  5 Write addr=7 -> shadow unchanged, cfg_err=1 sticky; vout with 0 outstanding -> cfg_err=1.
//  6 Assert rst_n=0 mid-DRAIN -> state UNCFG, coefs 0, cfg_busy=0, outstanding 0.

Source files
------------

// File: rtl/iir_cfg_pkg.sv
// Shared types and constants for the IIR coefficient/sample controller.
package iir_cfg_pkg;

   // Controller phases: waiting for first config, running, draining, swapping
   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      SWAP  = 2'd3
   } state_t;

   localparam int NCOEF = 6;

   // Coefficient addresses on the configuration port
   localparam logic [2:0] ADDR_C0 = 3'd0;
   localparam logic [2:0] ADDR_C1 = 3'd1;
   localparam logic [2:0] ADDR_C2 = 3'd2;
   localparam logic [2:0] ADDR_B0 = 3'd3;
   localparam logic [2:0] ADDR_B1 = 3'd4;
   localparam logic [2:0] ADDR_B2 = 3'd5;

   // True for addresses that map onto a coefficient slot
   function automatic logic addr_valid(input logic [2:0] addr);
      return addr < 3'(NCOEF);
   endfunction

endpackage

// File: rtl/iir_cfg_ctrl_coef_bank.sv
// Shadow + active coefficient registers. Writes land in the shadow copy;
// the swap strobe copies every shadow slot into the active copy at once.
module coef_bank
   import iir_cfg_pkg::*;
#(
   parameter int W = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               we,
   input  logic [2:0]         addr,
   input  logic [W-1:0]       data,
   input  logic               swap,
   output logic [NCOEF*W-1:0] coef_flat
);

   for (genvar gi = 0; gi < NCOEF; gi++) begin : g_coef
      logic [W-1:0] shadow_reg;
      logic [W-1:0] active_reg;

      // Per-slot shadow write and atomic shadow->active copy on swap
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
         end else begin
            if (we && (addr == 3'(gi)))
               shadow_reg <= data;
            if (swap)
               active_reg <= shadow_reg;
         end
      end

      assign coef_flat[gi*W +: W] = active_reg;
   end

endmodule

// File: rtl/iir_cfg_ctrl.sv
// Controller between the sample source and the IIR datapath: forwards samples,
// tracks samples in flight and swaps coefficient sets only once the filter is empty.
module iir_cfg_ctrl
   import iir_cfg_pkg::*;
#(
   parameter int W    = 9,
   parameter int OUTW = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_we,
   input  logic [2:0]   cfg_addr,
   input  logic [W-1:0] cfg_data,
   input  logic         cfg_commit,
   output logic         cfg_busy,
   output logic         cfg_err,
   input  logic [W-1:0] din_up,
   input  logic         vin_up,
   output logic         rdy_up,
   output logic [W-1:0] din,
   output logic         vin,
   input  logic         vout,
   output logic [W-1:0] c0,
   output logic [W-1:0] c1,
   output logic [W-1:0] c2,
   output logic [W-1:0] b0,
   output logic [W-1:0] b1,
   output logic [W-1:0] b2
);

   localparam logic [OUTW-1:0] OUT_MAX = '1;

   state_t              state_reg;
   logic                busy_reg;
   logic                err_reg;
   logic                vin_reg;
   logic [W-1:0]        din_reg;
   logic [OUTW-1:0]     outst_reg;
   logic                xfer;
   logic                drain_done;
   logic                swap;
   logic [NCOEF*W-1:0]  coef_flat;

   // Input is accepted only while running and not in the cycle a commit arrives
   assign rdy_up     = (state_reg == RUN) & ~cfg_commit;
   assign xfer       = vin_up & rdy_up;
   // Filter is empty: nothing outstanding and nothing entering this cycle
   assign drain_done = (outst_reg == '0) & ~vin_reg;
   assign swap       = (state_reg == SWAP);

   // Commit sequencing: stall, drain, swap, resume; busy is registered with the state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= UNCFG;
         busy_reg  <= 1'b0;
      end else begin
         case (state_reg)
            UNCFG, RUN: begin
               if (cfg_commit) begin
                  state_reg <= DRAIN;
                  busy_reg  <= 1'b1;
               end
            end
            DRAIN: begin
               if (drain_done)
                  state_reg <= SWAP;
            end
            SWAP: begin
               state_reg <= RUN;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= UNCFG;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   // One-cycle forwarding register; data held when nothing is transferred
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vin_reg <= 1'b0;
         din_reg <= '0;
      end else begin
         vin_reg <= xfer;
         if (xfer)
            din_reg <= din_up;
      end
   end

   // In-flight counter with saturation/underflow protection and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outst_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         if (vin_reg && !vout) begin
            if (outst_reg == OUT_MAX)
               err_reg <= 1'b1;
            else
               outst_reg <= outst_reg + 1'b1;
         end else if (vout && !vin_reg) begin
            if (outst_reg == '0)
               err_reg <= 1'b1;
            else
               outst_reg <= outst_reg - 1'b1;
         end
         if (cfg_we && !addr_valid(cfg_addr))
            err_reg <= 1'b1;
      end
   end

   coef_bank #(.W(W)) u_coef_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (cfg_we),
      .addr      (cfg_addr),
      .data      (cfg_data),
      .swap      (swap),
      .coef_flat (coef_flat)
   );

   assign c0       = coef_flat[int'(ADDR_C0)*W +: W];
   assign c1       = coef_flat[int'(ADDR_C1)*W +: W];
   assign c2       = coef_flat[int'(ADDR_C2)*W +: W];
   assign b0       = coef_flat[int'(ADDR_B0)*W +: W];
   assign b1       = coef_flat[int'(ADDR_B1)*W +: W];
   assign b2       = coef_flat[int'(ADDR_B2)*W +: W];
   assign vin      = vin_reg;
   assign din      = din_reg;
   assign cfg_busy = busy_reg;
   assign cfg_err  = err_reg;

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Directed + randomized bench for iir_cfg_ctrl against a transaction-level model.
module tb_iir_cfg_ctrl;

   logic       clk;
   logic       rst_n;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [8:0] cfg_data;
   logic       cfg_commit;
   logic       cfg_busy;
   logic       cfg_err;
   logic [8:0] din_up;
   logic       vin_up;
   logic       rdy_up;
   logic [8:0] din;
   logic       vin;
   logic       vout;
   logic [8:0] c0, c1, c2, b0, b1, b2;
   logic [8:0] dut_coef [6];

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   // Model: phase 0=unconfigured 1=running 2=draining 3=swapping
   int         m_phase;
   int         m_inflight;
   logic       m_vin;
   logic [8:0] m_din;
   logic       m_err;
   logic [8:0] m_shadow [6];
   logic [8:0] m_active [6];

   iir_cfg_ctrl #(.W(9), .OUTW(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_commit (cfg_commit),
      .cfg_busy   (cfg_busy),
      .cfg_err    (cfg_err),
      .din_up     (din_up),
      .vin_up     (vin_up),
      .rdy_up     (rdy_up),
      .din        (din),
      .vin        (vin),
      .vout       (vout),
      .c0         (c0),
      .c1         (c1),
      .c2         (c2),
      .b0         (b0),
      .b1         (b1),
      .b2         (b2)
   );

   assign dut_coef[0] = c0;
   assign dut_coef[1] = c1;
   assign dut_coef[2] = c2;
   assign dut_coef[3] = b0;
   assign dut_coef[4] = b1;
   assign dut_coef[5] = b2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_phase    = 0;
      m_inflight = 0;
      m_vin      = 1'b0;
      m_din      = '0;
      m_err      = 1'b0;
      for (int k = 0; k < 6; k++) begin
         m_shadow[k] = '0;
         m_active[k] = '0;
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven
   task automatic m_edge();
      int   next_phase;
      logic accept;
      accept     = vin_up && (m_phase == 1) && !cfg_commit;
      next_phase = m_phase;
      if ((m_phase == 0 || m_phase == 1) && cfg_commit) next_phase = 2;
      else if (m_phase == 2 && m_inflight == 0 && !m_vin) next_phase = 3;
      else if (m_phase == 3) next_phase = 1;
      if (m_phase == 3)
         for (int k = 0; k < 6; k++) m_active[k] = m_shadow[k];
      if (cfg_we) begin
         if (cfg_addr < 3'd6) m_shadow[cfg_addr] = cfg_data;
         else m_err = 1'b1;
      end
      if (m_vin && !vout) begin
         if (m_inflight == 15) m_err = 1'b1;
         else m_inflight++;
      end else if (vout && !m_vin) begin
         if (m_inflight == 0) m_err = 1'b1;
         else m_inflight--;
      end
      m_phase = next_phase;
      m_vin   = accept;
      if (accept) m_din = din_up;
   endtask

   task automatic chk_outputs();
      chk("vin", vin, m_vin);
      chk("din", din, m_din);
      chk("busy", cfg_busy, (m_phase >= 2));
      chk("err", cfg_err, m_err);
      for (int k = 0; k < 6; k++) chk($sformatf("coef%0d", k), dut_coef[k], m_active[k]);
   endtask

   // One clock cycle: drive inputs, check ready, clock, check registered outputs
   task automatic cyc(input logic we, input logic [2:0] a, input logic [8:0] d,
                      input logic cm, input logic vu, input logic [8:0] du, input logic vo);
      cfg_we = we; cfg_addr = a; cfg_data = d; cfg_commit = cm;
      vin_up = vu; din_up = du; vout = vo;
      #1;
      chk("rdy_up", rdy_up, (m_phase == 1) && !cm);
      @(posedge clk);
      m_edge();
      #1;
      chk_outputs();
      $display("cyc t=%0t we=%0b a=%0d cm=%0b vu=%0b vo=%0b | rdy=%0b vin=%0b busy=%0b err=%0b",
               $time, we, a, cm, vu, vo, rdy_up, vin, cfg_busy, cfg_err);
   endtask

   task automatic idle();
      cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b0, 9'd0, 1'b0);
   endtask

   // Asynchronous reset pulse asserted between clock edges
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      chk("rst_busy", cfg_busy, 1'b0);
      chk("rst_vin", vin, 1'b0);
      for (int k = 0; k < 6; k++) chk($sformatf("rst_coef%0d", k), dut_coef[k], 9'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [8:0] exp_set [6];
      int guard;
      rst_n = 1'b0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; cfg_commit = 0;
      vin_up = 0; din_up = 0; vout = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", cfg_busy, 1'b0);
      chk("reset_err", cfg_err, 1'b0);
      chk_outputs();
      rst_n = 1'b1;

      // 1: unconfigured, upstream valid is blocked
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'($urandom), 1'b0);
         chk("t1_rdy", rdy_up, 1'b0);
         chk("t1_vin", vin, 1'b0);
      end

      // 2: load 1..6, commit with nothing in flight -> two busy cycles
      for (int i = 0; i < 6; i++) cyc(1'b1, 3'(i), 9'(i + 1), 1'b0, 1'b0, 9'd0, 1'b0);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      chk("t2_busy1", cfg_busy, 1'b1);
      idle();
      chk("t2_busy2", cfg_busy, 1'b1);
      idle();
      chk("t2_busy3", cfg_busy, 1'b0);
      for (int k = 0; k < 6; k++) chk($sformatf("t2_coef%0d", k), dut_coef[k], 9'(k + 1));
      chk("t2_rdy", rdy_up, 1'b1);

      // 3: three samples in flight, commit, drain on three vout pulses
      cyc(1'b1, 3'd3, 9'h1FF, 1'b0, 1'b0, 9'd0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'($urandom), 1'b0);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b1, 9'($urandom), 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'($urandom), 1'b0);
         chk("t3_b0_hold", b0, 9'd4);
         chk("t3_rdy_drain", rdy_up, 1'b0);
         cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'($urandom), 1'b1);
         chk("t3_b0_hold", b0, 9'd4);
      end
      idle();
      chk("t3_swap_busy", cfg_busy, 1'b1);
      chk("t3_b0_pre", b0, 9'd4);
      idle();
      chk("t3_b0_new", b0, 9'h1FF);

      // 4: write with commit is included; write during SWAP waits for next commit
      cyc(1'b1, 3'd5, 9'h0AA, 1'b1, 1'b0, 9'd0, 1'b0);
      idle();
      cyc(1'b1, 3'd5, 9'h055, 1'b0, 1'b0, 9'd0, 1'b0);
      chk("t4_b2_commit", b2, 9'h0AA);
      idle();
      chk("t4_b2_held", b2, 9'h0AA);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      idle();
      idle();
      chk("t4_b2_next", b2, 9'h055);

      // 5: invalid address sets sticky error and leaves coefficients alone
      cyc(1'b1, 3'd7, 9'h123, 1'b0, 1'b0, 9'd0, 1'b0);
      chk("t5_err", cfg_err, 1'b1);
      idle();
      chk("t5_err_sticky", cfg_err, 1'b1);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      idle();
      idle();
      exp_set = '{9'd1, 9'd2, 9'd3, 9'h1FF, 9'd5, 9'h055};
      for (int k = 0; k < 6; k++) chk($sformatf("t5_coef%0d", k), dut_coef[k], exp_set[k]);

      // Randomized traffic
      for (int i = 0; i < 300; i++)
         cyc(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 9'($urandom),
             ($urandom_range(0, 15) == 0), 1'($urandom), 9'($urandom),
             (m_inflight > 0) ? 1'($urandom) : 1'b0);

      // Bring controller back to running with nothing outstanding
      guard = 0;
      while ((m_phase != 1 || m_inflight != 0 || m_vin) && guard < 100) begin
         cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b0, 9'd0, (m_inflight > 0));
         guard++;
      end
      chk("settle_busy", cfg_busy, 1'b0);
      chk("settle_rdy", rdy_up, 1'b1);

      // 6: reset in the middle of a drain
      cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'h011, 1'b0);
      cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'h022, 1'b0);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      chk("t6_draining", cfg_busy, 1'b1);
      async_reset();
      chk("t6_err_clr", cfg_err, 1'b0);
      cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'd0, 1'b1);
      chk("t6_rdy_uncfg", rdy_up, 1'b0);
      chk("t6_vout_zero", cfg_err, 1'b1);

      // Counter saturation: 16 samples with no vout
      async_reset();
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      idle();
      idle();
      for (int i = 0; i < 16; i++) cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b1, 9'(i), 1'b0);
      chk("sat_err_pre", cfg_err, 1'b0);
      idle();
      chk("sat_err", cfg_err, 1'b1);
      cyc(1'b0, 3'd0, 9'd0, 1'b1, 1'b0, 9'd0, 1'b0);
      for (int i = 0; i < 15; i++) cyc(1'b0, 3'd0, 9'd0, 1'b0, 1'b0, 9'd0, 1'b1);
      chk("sat_still_busy", cfg_busy, 1'b1);
      idle();
      idle();
      chk("sat_done", cfg_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
